// File: rtl/sp_core_param.sv
// sp_core_param: parametrised multi-cycle MIPS-lite core with register file, data memory and 2-cycle load path
module sp_core_param #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int DMEM_DEPTH = 4096,
  parameter int R0_ZERO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] inst,
  output logic        out_valid,
  output logic [31:0] inst_addr,
  output logic        busy,
  output logic        illegal
);
  localparam int RW = $clog2(NREG);
  localparam int AW = $clog2(DMEM_DEPTH);
  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] r [0:NREG-1];
  logic [XLEN-1:0] mem [0:DMEM_DEPTH-1];
  logic [31:0] ir, pc4, pc_nx;
  logic [XLEN-1:0] ld_data, a, b, sext, zext, alu, wr_data;
  logic [5:0] op, func;
  logic [RW-1:0] rs_i, rt_i, rd_i, wr_idx;
  logic [AW-1:0] ea;
  logic legal, wr_en, mem_we, retire;
  assign op = ir[31:26];
  assign func = ir[5:0];
  assign rs_i = ir[21 +: RW];
  assign rt_i = ir[16 +: RW];
  assign rd_i = ir[11 +: RW];
  assign a = (R0_ZERO != 0 && rs_i == '0) ? '0 : r[rs_i];
  assign b = (R0_ZERO != 0 && rt_i == '0) ? '0 : r[rt_i];
  assign sext = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign zext = {{(XLEN-16){1'b0}}, ir[15:0]};
  assign ea = AW'(a + sext);
  assign pc4 = inst_addr + 32'd4;
  assign legal = (op == 6'h00) ? func <= 6'h07 : op <= 6'h0B;
  assign busy = state != IDLE;
  // R-type datapath selected by the low func bits
  always_comb begin
    alu = '0;
    case (func[2:0])
      3'd0: alu = a & b;
      3'd1: alu = a | b;
      3'd2: alu = a + b;
      3'd3: alu = a - b;
      3'd4: alu = ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      3'd5: alu = a << ir[10:6];
      3'd6: alu = ~(a | b);
      default: alu = '0;
    endcase
  end
  // next state, register/memory write enables and next PC
  always_comb begin
    state_nx = state;
    wr_en = 1'b0;
    wr_idx = rt_i;
    wr_data = '0;
    mem_we = 1'b0;
    retire = 1'b0;
    pc_nx = pc4;
    case (state)
      IDLE: state_nx = in_valid ? EXEC : IDLE;
      EXEC: begin
        state_nx = (op == 6'h05) ? MEM : IDLE;
        retire = op != 6'h05;
        case (op)
          6'h00: begin
            wr_en = func < 6'h07;
            wr_idx = rd_i;
            wr_data = alu;
            pc_nx = (func == 6'h07) ? a[31:0] : pc4;
          end
          6'h01: {wr_en, wr_data} = {1'b1, a & zext};
          6'h02: {wr_en, wr_data} = {1'b1, a | zext};
          6'h03: {wr_en, wr_data} = {1'b1, a + sext};
          6'h04: {wr_en, wr_data} = {1'b1, a - sext};
          6'h06: mem_we = 1'b1;
          6'h07: pc_nx = (a == b) ? pc4 + {sext[29:0], 2'b00} : pc4;
          6'h08: pc_nx = (a != b) ? pc4 + {sext[29:0], 2'b00} : pc4;
          6'h09: {wr_en, wr_data} = {1'b1, zext << 16};
          6'h0A: pc_nx = {inst_addr[31:28], ir[25:0], 2'b00};
          6'h0B: begin
            wr_en = 1'b1;
            wr_idx = RW'(NREG - 1);
            wr_data = XLEN'(pc4);
            pc_nx = {inst_addr[31:28], ir[25:0], 2'b00};
          end
          default: ;
        endcase
      end
      MEM: begin
        state_nx = IDLE;
        retire = 1'b1;
        wr_en = 1'b1;
        wr_data = ld_data;
      end
      default: state_nx = IDLE;
    endcase
    if (R0_ZERO != 0 && wr_idx == '0) wr_en = 1'b0;
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // architectural state: PC, retire flags, instruction latch, load buffer, register file
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_addr <= '0;
      out_valid <= 1'b0;
      illegal <= 1'b0;
      ir <= '0;
      ld_data <= '0;
      for (int i = 0; i < NREG; i++) r[i] <= '0;
    end else begin
      out_valid <= retire;
      illegal <= retire && !legal;
      if (state == IDLE && in_valid) ir <= inst;
      if (state == EXEC) ld_data <= mem[ea];
      if (retire) inst_addr <= pc_nx;
      if (wr_en) r[wr_idx] <= wr_data;
    end
  end
  // data memory, deliberately left out of reset
  always_ff @(posedge clk) if (!rst && mem_we) mem[ea] <= b;
endmodule

// File: tb/tb_sp_core_param.sv
// tb_sp_core_param: two configurations driven in lockstep against a behavioural ISA model
module tb_sp_core_param;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [31:0] inst = '0;
  logic ov0, ov1, il0, il1, bz0, bz1;
  logic [31:0] ia0, ia1;
  int checks = 0, errors = 0;
  int xl [2] = '{32, 64};
  int nr [2] = '{32, 8};
  int dd [2] = '{4096, 16};
  bit rz [2] = '{1'b0, 1'b1};
  logic [63:0] mr [2][32];
  logic [63:0] mm [2][4096];
  logic [31:0] mpc [2];
  always #5 clk = ~clk;
  sp_core_param d0 (.clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst),
    .out_valid(ov0), .inst_addr(ia0), .busy(bz0), .illegal(il0));
  sp_core_param #(.XLEN(64), .NREG(8), .DMEM_DEPTH(16), .R0_ZERO(1)) d1 (.clk(clk), .rst(rst),
    .in_valid(in_valid), .inst(inst), .out_valid(ov1), .inst_addr(ia1), .busy(bz1), .illegal(il1));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] regrd(input int c, input int i);
    int k;
    k = i % nr[c];
    return (rz[c] && k == 0) ? 64'd0 : mr[c][k];
  endfunction
  task automatic regwr(input int c, input int i, input logic [63:0] v);
    int k;
    k = i % nr[c];
    if (!(rz[c] && k == 0)) mr[c][k] = (xl[c] == 32) ? (v & 64'hFFFF_FFFF) : v;
  endtask
  task automatic mreset();
    for (int c = 0; c < 2; c++) begin
      mpc[c] = '0;
      for (int i = 0; i < 32; i++) mr[c][i] = '0;
    end
  endtask
  task automatic step(input int c, input logic [31:0] w, output logic ill, output int ea);
    logic [63:0] m, a, b, se, ze, sa, sb;
    logic [31:0] pc4, npc;
    m = (xl[c] == 32) ? 64'hFFFF_FFFF : '1;
    a = regrd(c, int'(w[25:21]));
    b = regrd(c, int'(w[20:16]));
    se = {{48{w[15]}}, w[15:0]} & m;
    ze = {48'd0, w[15:0]};
    sa = (xl[c] == 32) ? {{32{a[31]}}, a[31:0]} : a;
    sb = (xl[c] == 32) ? {{32{b[31]}}, b[31:0]} : b;
    ea = int'((a + se) % 64'(dd[c]));
    pc4 = mpc[c] + 32'd4;
    npc = pc4;
    ill = 1'b0;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h00: regwr(c, int'(w[15:11]), a & b);
        6'h01: regwr(c, int'(w[15:11]), a | b);
        6'h02: regwr(c, int'(w[15:11]), a + b);
        6'h03: regwr(c, int'(w[15:11]), a - b);
        6'h04: regwr(c, int'(w[15:11]), ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0);
        6'h05: regwr(c, int'(w[15:11]), a << w[10:6]);
        6'h06: regwr(c, int'(w[15:11]), ~(a | b));
        6'h07: npc = a[31:0];
        default: ill = 1'b1;
      endcase
      6'h01: regwr(c, int'(w[20:16]), a & ze);
      6'h02: regwr(c, int'(w[20:16]), a | ze);
      6'h03: regwr(c, int'(w[20:16]), a + se);
      6'h04: regwr(c, int'(w[20:16]), a - se);
      6'h05: regwr(c, int'(w[20:16]), mm[c][ea]);
      6'h06: mm[c][ea] = b;
      6'h07: if (a == b) npc = pc4 + {se[29:0], 2'b00};
      6'h08: if (a != b) npc = pc4 + {se[29:0], 2'b00};
      6'h09: regwr(c, int'(w[20:16]), ze << 16);
      6'h0A: npc = {mpc[c][31:28], w[25:0], 2'b00};
      6'h0B: begin
        regwr(c, nr[c] - 1, {32'd0, pc4});
        npc = {mpc[c][31:28], w[25:0], 2'b00};
      end
      default: ill = 1'b1;
    endcase
    mpc[c] = npc;
  endtask
  task automatic check_arch();
    check("pc0", ia0, mpc[0]);
    check("pc1", ia1, mpc[1]);
    for (int i = 0; i < 32; i++) check($sformatf("d0.r%0d", i), d0.r[i], mr[0][i]);
    for (int i = 0; i < 8; i++) check($sformatf("d1.r%0d", i), d1.r[i], mr[1][i]);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    inst = 32'h0C01_FFFB;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    mreset();
    check("rst_busy0", bz0, 0);
    check("rst_busy1", bz1, 0);
    check("rst_ov0", ov0, 0);
    check("rst_ill0", il0, 0);
    check("rst_pc0", ia0, 0);
    check_arch();
  endtask
  task automatic issue(input logic [31:0] w);
    int n;
    logic e0, e1;
    int a0, a1;
    in_valid = 1'b1;
    inst = w;
    @(negedge clk);
    check("busy0", bz0, 1);
    check("busy1", bz1, 1);
    check("ill_quiet", il0, 0);
    n = 0;
    do begin
      inst = $urandom;
      @(negedge clk);
      n++;
    end while (!ov0 && n < 10);
    in_valid = 1'b0;
    step(0, w, e0, a0);
    step(1, w, e1, a1);
    check("latency", 64'(n), (w[31:26] == 6'h05) ? 64'd2 : 64'd1);
    check("ov1", ov1, 1);
    check("illegal0", il0, e0);
    check("illegal1", il1, e1);
    if (w[31:26] == 6'h06) begin
      check("mem0", d0.mem[a0], mm[0][a0]);
      check("mem1", d1.mem[a1], mm[1][a1]);
    end
    check_arch();
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 15);
    w[31:26] = (k < 12) ? 6'(k) : ((k == 12) ? 6'h3F : 6'h00);
    if (w[31:26] == 6'h00) w[5:0] = 6'($urandom_range(0, 8));
    return w;
  endfunction
  initial begin
    do_reset();
    for (int k = 0; k < 4096; k++) issue({6'h06, 10'd0, 16'(k)});
    do_reset();
    issue(32'h0C01_FFFB);
    check("addi_r1", d0.r[1], 64'hFFFF_FFFB);
    check("addi_pc", ia0, 4);
    issue({6'h00, 5'd1, 5'd1, 5'd2, 5'd0, 6'h03});
    check("sub_r2", d0.r[2], 0);
    check("sub_pc", ia0, 8);
    issue({6'h07, 5'd0, 5'd0, 16'hFFFF});
    check("beq_self", ia0, 8);
    issue({6'h06, 5'd0, 5'd1, 16'd3});
    check("sw_mem3", d0.mem[3], 64'hFFFF_FFFB);
    issue({6'h05, 5'd0, 5'd4, 16'd3});
    check("lw_r4", d0.r[4], 64'hFFFF_FFFB);
    issue({6'h03, 5'd0, 5'd5, 16'd17});
    issue({6'h06, 5'd5, 5'd1, 16'd0});
    check("ea_wrap", d1.mem[1], 64'hFFFF_FFFF_FFFF_FFFB);
    issue({6'h05, 5'd5, 5'd6, 16'd0});
    check("lw_wrap", d1.r[6], 64'hFFFF_FFFF_FFFF_FFFB);
    issue({6'h0A, 26'd8});
    check("j_pc", ia0, 32'h20);
    issue({6'h0B, 26'h10});
    check("jal_r31", d0.r[31], 32'h24);
    check("jal_r7", d1.r[7], 32'h24);
    check("jal_pc", ia0, 32'h40);
    issue({6'h00, 5'd31, 5'd0, 5'd0, 5'd0, 6'h07});
    check("jr_pc0", ia0, 32'h24);
    check("jr_pc1", ia1, 32'h24);
    issue({6'h00, 5'd5, 5'd0, 5'd9, 5'd0, 6'h02});
    check("rd9_alias", d1.r[1], 17);
    issue({6'h03, 5'd0, 5'd0, 16'd7});
    check("r0_plain", d0.r[0], 7);
    check("r0_zero", d1.r[0], 0);
    issue(32'hFC00_1234);
    check("illegal_op", il0, 1);
    issue({6'h00, 5'd1, 5'd1, 5'd3, 5'd0, 6'h08});
    check("illegal_func", il0, 1);
    in_valid = 1'b1;
    inst = {6'h05, 5'd0, 5'd4, 16'd3};
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", bz0, 1);
    check("mid_ov", ov0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mreset();
    check("abort_ov", ov0, 0);
    check("abort_pc", ia0, 0);
    check("abort_r4", d0.r[4], 0);
    check_arch();
    @(negedge clk);
    check("abort_late_ov", ov0, 0);
    for (int k = 0; k < 600; k++) issue(rnd_inst());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sp_core_param.md
# sp_core_param

Parametrised multi-cycle successor of the single-issue MIPS-lite core. It accepts one instruction per `in_valid` pulse, executes it against an internal register file and data memory, and updates the program counter. It then pulses `out_valid` with the next `inst_addr`. Compared with the fixed core it adds:

- configurable data width, register count and memory depth
- optional hardwired-zero r0
- a 2-cycle load path
- a `busy` flag and an illegal-instruction flag

It sits between the instruction source (testbench or fetch unit) and nothing else; `r` and `mem` arrays stay hierarchically visible for checking.

## Interface
- XLEN, 32, data/register width; legal values 32 or 64
- NREG, 32, register count; legal 8, 16, 32; register index = 5-bit field mod NREG
- DMEM_DEPTH, 4096, data memory words; power of two
- R0_ZERO, 0, 1 = r0 reads 0 and ignores writes; 0 = r0 is an ordinary register
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  `inst` is valid this cycle
- inst  in  32  instruction word
- out_valid  out  1  one-cycle pulse: instruction retired
- inst_addr  out  32  PC of next instruction
- busy  out  1  high while an instruction is in flight
- illegal  out  1  qualifies `out_valid`: retired instruction was undefined

## Operation
- Arrays: `r[0:NREG-1]` of XLEN bits, named `r`; `mem[0:DMEM_DEPTH-1]` of XLEN bits, named `mem`.
- Reset clears `r`; `mem` is not reset.
- Fields:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], func = [5:0], imm = [15:0], addr = [25:0]
  - sext = imm sign-extended to XLEN; zext = imm zero-extended to XLEN
- R-type (op 0x00), by func:
  - 00 and, 01 or, 02 add, 03 sub: write rd
  - 04 slt: signed compare, rd = 1/0
  - 05 sll: rd = rs << shamt
  - 06 nor: write rd
  - 07 jr: PC = r[rs][31:0]
- I-type (op):
  - 01 andi (zext), 02 ori (zext), 03 addi (sext), 04 subi (sext): write rt
  - 05 lw: rt = mem[ea]
  - 06 sw: mem[ea] = rt
  - 07 beq, 08 bne: taken PC = PC + 4 + (sext << 2)
  - 09 lui: rt = zext << 16
- J-type:
  - 0A j: PC = {PC[31:28], addr, 2'b00}
  - 0B jal: r[NREG-1] = PC + 4, then jump as j
- Effective address: ea = (r[rs] + sext) mod DMEM_DEPTH, i.e. low log2(DMEM_DEPTH) bits.
- Arithmetic wraps modulo 2^XLEN; PC arithmetic wraps modulo 2^32.
- Every non-control instruction sets PC = PC + 4; a branch not taken also sets PC + 4.
- Illegal instruction (any other op, or op 0 with func > 07):
  - no register or memory change
  - PC + 4
  - `illegal` = 1
- Register reads use pre-instruction values (rs == rd is legal).
- With R0_ZERO = 1, reads of r0 return 0 and writes to r0 are dropped.
- FSM states: IDLE, EXEC, MEM.
  - IDLE: `in_valid` = 1 latches `inst`, goes to EXEC.
  - EXEC, lw: reads `mem`, goes to MEM.
  - EXEC, all other instructions: commit and retire, go to IDLE.
  - MEM: writes rt, retires, goes to IDLE.
- `busy` = (state != IDLE).
- `in_valid` while `busy` is ignored; the instruction is dropped with no side effect.

## Timing
- Reset values: `out_valid` 0, `inst_addr` 0, `busy` 0, `illegal` 0, all `r` 0, state IDLE.
- `rst` wins over `in_valid` in the same cycle.
- `rst` mid-instruction aborts it: no commit, no `out_valid`, state returns to IDLE.
- Instruction sampled at edge T (`in_valid` high):
  - Non-load: `r`, `mem`, `inst_addr` and `out_valid` = 1 are visible after edge T+1.
  - Load: the same outputs are visible after edge T+2.
- `out_valid` and `illegal` are high for exactly one cycle; `illegal` is 0 whenever `out_valid` is 0.
- `inst_addr` holds between retirements.
- Back-to-back issue: the next instruction may be presented in the cycle `out_valid` is high (state already IDLE).
  - Its sampled registers include the just-committed result.
- Maximum latency is 2 cycles, which is well inside the bench's 10-cycle limit.

## Test plan
- Reset check:
  - Stimulus: `rst` high for 1 cycle, default parameters.
  - Response: `inst_addr` 0, `out_valid` 0, `busy` 0, all `r` 0.
- addi then sub:
  - Stimulus: addi r1, r0, -5 (0x0C01FFFB); then sub r2, r1, r1.
  - Response: r1 = 0xFFFFFFFB with `out_valid` at T+1 and `inst_addr` 4; then r2 = 0, `inst_addr` 8.
- Load and store:
  - Stimulus: sw r1 → mem[3]; then lw r4 from mem[3].
  - Response: mem[3] = r1 at T+1; lw `out_valid` exactly at T+2 with r4 = r1; `busy` high during T+1.
  - Stimulus: ea wraps at DMEM_DEPTH = 16.
  - Response: r[rs] = 17, imm 0 accesses mem[1].
- Branch and jump:
  - Stimulus: beq r0, r0, imm -1 at PC 8.
  - Response: `inst_addr` 8.
  - Stimulus: jal addr 0x10 at PC 0x20.
  - Response: r31 = 0x24, `inst_addr` 0x40.
  - Stimulus: jr r31.
  - Response: `inst_addr` 0x24.
- R0_ZERO and NREG:
  - Stimulus: R0_ZERO = 1, addi r0, r0, 7.
  - Response: r0 = 0.
  - Stimulus: NREG = 8, jal.
  - Response: writes r7; rd field 9 maps to r1.
- Illegal, busy-drop and mid-load reset:
  - Stimulus: op 0x3F.
  - Response: `illegal` = 1 with `out_valid`, PC + 4, no register changes.
  - Stimulus: `in_valid` during a lw's MEM cycle.
  - Response: ignored.
  - Stimulus: `rst` during MEM.
  - Response: no rt write, `inst_addr` 0.
